// File: rtl/vga_pkg.sv
// Shared VGA-path types and constants for the sprite/tile drawers.
package vga_pkg;

  localparam int H_ACTIVE = 640;
  localparam int V_ACTIVE = 480;

  typedef struct packed {
    logic [3:0] r;
    logic [3:0] g;
    logic [3:0] b;
  } rgb12_t;

  typedef enum logic [1:0] {
    MODE_NORMAL    = 2'd0,
    MODE_HIGHLIGHT = 2'd1,
    MODE_BLINK     = 2'd2,
    MODE_HIDDEN    = 2'd3
  } tile_mode_e;

  function automatic logic [3:0] sat_add4(input logic [3:0] a, input logic [3:0] b);
    logic [4:0] s;
    s = {1'b0, a} + {1'b0, b};
    return s[4] ? 4'hF : s[3:0];
  endfunction

endpackage

// File: rtl/sprite_tile_renderer_if.sv
// Sprite ROM / palette fetch bus between a renderer (master) and its memories (slave).
interface sprite_tile_renderer_if #(
  parameter int ADDR_W = 11,
  parameter int PIX_W  = 1
);
  // No valid/ready: rom_q must reflect rom_addr one clock later, and
  // pal_rgb must be a purely combinational lookup of pal_idx.
  logic [ADDR_W-1:0] rom_addr;
  logic [PIX_W-1:0]  rom_q;
  logic [PIX_W-1:0]  pal_idx;
  logic [11:0]       pal_rgb;

  modport master (output rom_addr, output pal_idx, input rom_q, input pal_rgb);
  modport slave  (input rom_addr, input pal_idx, output rom_q, output pal_rgb);
endinterface

// File: rtl/sprite_tile_renderer_blink_timer.sv
// Frame-start detector and blink phase generator; one instance can feed many renderers.
module sprite_blink_timer #(
  parameter int BLINK_FRAMES = 15
) (
  input  logic       vga_clk,
  input  logic       reset_n,
  input  logic [9:0] DrawY,
  output logic       frame_start,
  output logic       blink_phase
);
  localparam int CNT_W = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

  logic [9:0]       prev_y;
  logic [CNT_W-1:0] frame_cnt;

  assign frame_start = (DrawY == 10'd0) && (prev_y != 10'd0);

  always_ff @(posedge vga_clk) begin
    if (!reset_n) begin
      prev_y      <= '0;
      frame_cnt   <= '0;
      blink_phase <= 1'b1;
    end else begin
      prev_y <= DrawY;
      if (frame_start) begin
        if (frame_cnt == CNT_W'(BLINK_FRAMES - 1)) begin
          frame_cnt   <= '0;
          blink_phase <= ~blink_phase;
        end else begin
          frame_cnt <= frame_cnt + CNT_W'(1);
        end
      end
    end
  end

endmodule

// File: rtl/sprite_tile_renderer.sv
// Palette-indexed sprite drawer with per-tile display mode; 3-clock pixel latency
// from DrawX/DrawY/blank to red/green/blue, fetching through an external sync ROM.
module sprite_tile_renderer
  import vga_pkg::*;
#(
  parameter int          SPRITE_W     = 35,
  parameter int          SPRITE_H     = 32,
  parameter int          ADDR_W       = 11,
  parameter int          PIX_W        = 1,
  parameter int          TRANSP_IDX   = 0,
  parameter logic [11:0] BG_COLOR     = 12'h000,
  parameter logic [3:0]  HL_ADD       = 4'h4,
  parameter int          BLINK_FRAMES = 15
) (
  input  logic                    vga_clk,
  input  logic                    reset_n,
  input  logic [9:0]              DrawX,
  input  logic [9:0]              DrawY,
  input  logic                    blank,
  input  logic [9:0]              pos_x,
  input  logic [9:0]              pos_y,
  input  logic [1:0]              mode,
  sprite_tile_renderer_if.master  fetch,
  output logic [3:0]              red,
  output logic [3:0]              green,
  output logic [3:0]              blue
);

  logic frame_start;
  logic blink_phase;

  sprite_blink_timer #(.BLINK_FRAMES(BLINK_FRAMES)) u_blink (
    .vga_clk     (vga_clk),
    .reset_n     (reset_n),
    .DrawY       (DrawY),
    .frame_start (frame_start),
    .blink_phase (blink_phase)
  );

  // Shadow copies only move at frame start; in that cycle the incoming
  // values are used directly so row 0 of the new frame is already correct.
  logic [9:0] px_sh, py_sh;
  tile_mode_e mode_sh;
  logic [9:0] px_eff, py_eff;
  tile_mode_e mode_eff;

  always_comb begin
    px_eff   = frame_start ? pos_x : px_sh;
    py_eff   = frame_start ? pos_y : py_sh;
    mode_eff = frame_start ? tile_mode_e'(mode) : mode_sh;
  end

  always_ff @(posedge vga_clk) begin
    if (!reset_n) begin
      px_sh   <= '0;
      py_sh   <= '0;
      mode_sh <= MODE_NORMAL;
    end else if (frame_start) begin
      px_sh   <= pos_x;
      py_sh   <= pos_y;
      mode_sh <= tile_mode_e'(mode);
    end
  end

  // Stage 0: hit test in 11 bits so pos + size never wraps.
  logic [10:0] x11, y11, px11, py11;
  logic        hit;

  assign x11  = {1'b0, DrawX};
  assign y11  = {1'b0, DrawY};
  assign px11 = {1'b0, px_eff};
  assign py11 = {1'b0, py_eff};

  assign hit = (x11 >= px11) && (x11 < px11 + 11'(SPRITE_W)) &&
               (y11 >= py11) && (y11 < py11 + 11'(SPRITE_H)) &&
               (mode_eff != MODE_HIDDEN);

  // Row base advances by SPRITE_W on each new sprite row instead of multiplying.
  logic [9:0]        prev_y;
  logic [ADDR_W-1:0] row_base, row_base_next, addr;

  always_comb begin
    row_base_next = row_base;
    if (DrawY != prev_y) begin
      if (DrawY == py_eff) begin
        row_base_next = '0;
      end else if ((y11 > py11) && (y11 < py11 + 11'(SPRITE_H))) begin
        row_base_next = row_base + ADDR_W'(SPRITE_W);
      end
    end
  end

  assign addr = row_base_next + ADDR_W'(x11 - px11);

  logic [ADDR_W-1:0] rom_addr_r;
  logic              hit_d1, hit_d2, blank_d1, blank_d2;
  tile_mode_e        mode_d1, mode_d2;
  rgb12_t            pal, pix_next;

  assign fetch.rom_addr = rom_addr_r;
  assign fetch.pal_idx  = fetch.rom_q;
  assign pal            = fetch.pal_rgb;

  always_comb begin
    pix_next = pal;
    if (!blank_d2) begin
      pix_next = '0;
    end else if (!hit_d2 || (fetch.rom_q == PIX_W'(TRANSP_IDX))) begin
      pix_next = BG_COLOR;
    end else if ((mode_d2 == MODE_BLINK) && !blink_phase) begin
      pix_next = BG_COLOR;
    end else if (mode_d2 == MODE_HIGHLIGHT) begin
      pix_next.r = sat_add4(pal.r, HL_ADD);
      pix_next.g = sat_add4(pal.g, HL_ADD);
      pix_next.b = sat_add4(pal.b, HL_ADD);
    end
  end

  always_ff @(posedge vga_clk) begin
    if (!reset_n) begin
      prev_y     <= '0;
      row_base   <= '0;
      rom_addr_r <= '0;
      hit_d1     <= 1'b0;
      hit_d2     <= 1'b0;
      blank_d1   <= 1'b0;
      blank_d2   <= 1'b0;
      mode_d1    <= MODE_NORMAL;
      mode_d2    <= MODE_NORMAL;
      red        <= '0;
      green      <= '0;
      blue       <= '0;
    end else begin
      prev_y     <= DrawY;
      row_base   <= row_base_next;
      rom_addr_r <= hit ? addr : '0;
      hit_d1     <= hit;
      blank_d1   <= blank;
      mode_d1    <= mode_eff;
      hit_d2     <= hit_d1;
      blank_d2   <= blank_d1;
      mode_d2    <= mode_d1;
      red        <= pix_next.r;
      green      <= pix_next.g;
      blue       <= pix_next.b;
    end
  end

endmodule

// File: tb/tb_sprite_tile_renderer.sv
// Randomised raster bench for sprite_tile_renderer against a per-pixel reference model.
module tb_sprite_tile_renderer;
  import vga_pkg::*;

  localparam int          SW     = 35;
  localparam int          SH     = 32;
  localparam int          AW     = 11;
  localparam int          PW     = 1;
  localparam int          BF     = 2;
  localparam int          TRANSP = 0;
  localparam int          HL     = 4;
  localparam logic [11:0] BG     = 12'h248;
  localparam int          NROWS  = 120;

  // clock / reset block
  logic vga_clk = 1'b0;
  always #5 vga_clk = ~vga_clk;
  logic reset_n;

  logic [9:0]  DrawX, DrawY, pos_x, pos_y;
  logic        blank;
  logic [1:0]  mode;
  logic [3:0]  red, green, blue;
  logic [11:0] pal_color;
  logic        rom_mem [0:(1<<AW)-1];

  sprite_tile_renderer_if #(.ADDR_W(AW), .PIX_W(PW)) fetch();

  always @(posedge vga_clk) fetch.rom_q <= rom_mem[fetch.rom_addr];
  assign fetch.pal_rgb = (fetch.pal_idx != '0) ? pal_color : 12'h5A3;

  sprite_tile_renderer #(
    .SPRITE_W(SW), .SPRITE_H(SH), .ADDR_W(AW), .PIX_W(PW), .TRANSP_IDX(TRANSP),
    .BG_COLOR(BG), .HL_ADD(4'(HL)), .BLINK_FRAMES(BF)
  ) dut (
    .vga_clk (vga_clk),
    .reset_n (reset_n),
    .DrawX   (DrawX),
    .DrawY   (DrawY),
    .blank   (blank),
    .pos_x   (pos_x),
    .pos_y   (pos_y),
    .mode    (mode),
    .fetch   (fetch),
    .red     (red),
    .green   (green),
    .blue    (blue)
  );

  // reference model state: what the frame was told at its start
  int sh_px, sh_py, sh_mode, n_fs, prev_row;
  logic [11:0] exp_q[$];
  int n_checks, n_errors;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic int model_phase();
    return 1 ^ ((n_fs / BF) % 2);
  endfunction

  function automatic logic [3:0] sat4(input logic [3:0] c);
    int s;
    s = int'(c) + HL;
    return (s > 15) ? 4'hF : 4'(s);
  endfunction

  function automatic logic [11:0] model_pixel(input int x, input int y, input logic bl,
                                              output logic [AW-1:0] a);
    bit   hit;
    int   addr;
    logic idx;
    hit  = (x >= sh_px) && (x < sh_px + SW) && (y >= sh_py) && (y < sh_py + SH) && (sh_mode != 3);
    addr = (y - sh_py) * SW + (x - sh_px);
    a    = hit ? AW'(addr) : '0;
    if (!bl) return 12'h000;
    if (!hit) return BG;
    idx = rom_mem[addr];
    if (idx == 1'(TRANSP)) return BG;
    if (sh_mode == 2 && model_phase() == 0) return BG;
    if (sh_mode == 1) return {sat4(pal_color[11:8]), sat4(pal_color[7:4]), sat4(pal_color[3:0])};
    return pal_color;
  endfunction

  // driver tasks
  task automatic drive_pixel(input int x, input int y, input logic bl);
    logic [AW-1:0] ea;
    logic [11:0]   ep;
    bit            fs;
    DrawX = 10'(x);
    DrawY = 10'(y);
    blank = bl;
    fs = (y == 0) && (prev_row != 0);
    if (fs) begin
      sh_px   = int'(pos_x);
      sh_py   = int'(pos_y);
      sh_mode = int'(mode);
      n_fs++;
    end
    prev_row = y;
    ep = model_pixel(x, y, bl, ea);
    exp_q.push_back(ep);
    @(posedge vga_clk);
    #1;
    check_eq("rom_addr", 32'(fetch.rom_addr), 32'(ea));
    if (exp_q.size() >= 3) check_eq("pixel", 32'({red, green, blue}), 32'(exp_q.pop_front()));
    if (fs) check_eq("blink_phase", 32'(dut.u_blink.blink_phase), 32'(model_phase()));
  endtask

  task automatic reset_cycle();
    reset_n  = 1'b0;
    sh_px    = 0;
    sh_py    = 0;
    sh_mode  = 0;
    n_fs     = 0;
    prev_row = 0;
    exp_q.delete();
    repeat (3) exp_q.push_back(12'h000);
    @(posedge vga_clk);
    #1;
    check_eq("rst_pixel", 32'({red, green, blue}), 32'(exp_q.pop_front()));
    check_eq("rst_rom_addr", 32'(fetch.rom_addr), 32'd0);
    check_eq("rst_blink_phase", 32'(dut.u_blink.blink_phase), 32'd1);
    reset_n = 1'b1;
  endtask

  task automatic run_frame(input int fpx, input int fpy, input logic [1:0] fmode,
                           input logic [11:0] fpal, input int chg_row, input int chg_px,
                           input int rst_row);
    pos_x     = 10'(fpx);
    pos_y     = 10'(fpy);
    mode      = fmode;
    pal_color = fpal;
    drive_pixel(5, NROWS - 1, 1'b1);
    for (int row = 0; row < NROWS; row++) begin
      if (row == chg_row) pos_x = 10'(chg_px);
      for (int i = 0; i < SW + 7; i++) begin
        int x;
        if (i < SW + 4)       x = sh_px - 2 + i;
        else if (i == SW + 4) x = 0;
        else if (i == SW + 5) x = 1;
        else                  x = int'(pos_x) + 3;
        if (x < 0) x = 0;
        if (row == rst_row && i == 10) reset_cycle();
        drive_pixel(x, row, (x < H_ACTIVE) && (row < V_ACTIVE) && ($urandom_range(0, 15) != 0));
      end
    end
  endtask

  initial begin
    n_checks  = 0;
    n_errors  = 0;
    reset_n   = 1'b0;
    DrawX     = '0;
    DrawY     = 10'(NROWS - 1);
    blank     = 1'b0;
    pos_x     = '0;
    pos_y     = '0;
    mode      = '0;
    pal_color = 12'hCE2;
    for (int i = 0; i < (1 << AW); i++) rom_mem[i] = i[0];

    repeat (3) reset_cycle();

    run_frame(100, 82, 2'd0, 12'hCE2, 90, 200, -1);
    run_frame(200, 82, 2'd2, 12'hCE2, -1, 0, -1);
    run_frame(200, 40, 2'd2, 12'h3B7, -1, 0, -1);
    run_frame(200, 40, 2'd2, 12'h3B7, -1, 0, -1);
    run_frame(620,  0, 2'd1, 12'hCE2, -1, 0, -1);
    run_frame(300, 10, 2'd3, 12'hFFF, -1, 0, -1);

    for (int i = 0; i < (1 << AW); i++) rom_mem[i] = 1'($urandom_range(0, 1));
    repeat (2) begin
      run_frame(int'($urandom_range(0, 630)), int'($urandom_range(0, 86)),
                2'($urandom_range(0, 3)), 12'($urandom), -1, 0, -1);
    end

    run_frame(100, 82, 2'd0, 12'h9C1, -1, 0, 90);
    run_frame(150, 60, 2'd2, 12'h9C1, -1, 0, -1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/sprite_tile_renderer.md
Name: sprite_tile_renderer

Overview:
- Parametrised successor to the fixed-offset instrument sprite drawers in the beat-sequencer VGA path.
- Draws one palette-indexed sprite of configurable size at a runtime (x,y) position, with a transparency index and a background colour.
- Adds per-tile display modes (normal / highlight / blink / hidden) so the step grid can mark the active step.
- Fetches pixels from an external synchronous sprite ROM and an external combinational palette; several instances are later priority-muxed in the colour mapper.

Parameters:
- SPRITE_W, 35, sprite width in pixels
- SPRITE_H, 32, sprite height in pixels
- ADDR_W, 11, ROM address width; must satisfy SPRITE_W*SPRITE_H <= 2**ADDR_W
- PIX_W, 1, palette index width
- TRANSP_IDX, 0, palette index treated as transparent
- BG_COLOR, 12'h000, {r,g,b} colour for transparent or outside-sprite pixels
- HL_ADD, 4'h4, highlight brightness added per channel, saturating
- BLINK_FRAMES, 15, frames per blink half-period; minimum 1

Ports:
- vga_clk, in, 1, pixel clock; all logic on its rising edge
- reset_n, in, 1, synchronous active-low reset
- DrawX, in, 10, current pixel column
- DrawY, in, 10, current pixel row
- blank, in, 1, 1 = active video (same polarity as existing drawers)
- pos_x, in, 10, sprite top-left column
- pos_y, in, 10, sprite top-left row
- mode, in, 2, 0 normal, 1 highlight, 2 blink, 3 hidden
- rom_addr, out, ADDR_W, registered ROM address
- rom_q, in, PIX_W, ROM data, valid one clock after rom_addr
- pal_idx, out, PIX_W, palette index (rom_q passthrough)
- pal_rgb, in, 12, combinational palette result {r[3:0],g[3:0],b[3:0]}
- red, out, 4, pixel colour
- green, out, 4, pixel colour
- blue, out, 4, pixel colour

Behaviour:
- Frame start: the cycle in which DrawY changes to 0 from nonzero. pos_x, pos_y and mode are latched into shadow registers only at frame start. No tearing on mid-frame changes.
- Hit test (stage 0, combinational on inputs and shadows):
  - Compare in 11 bits so that pos + size never wraps.
  - hit = DrawX >= px && DrawX < px+SPRITE_W && DrawY >= py && DrawY < py+SPRITE_H && shadow mode != 3.
- Row base (no multiplier):
  - Register prev_y.
  - When DrawY != prev_y: row_base <= 0 if DrawY == py; else if DrawY is inside the sprite rows, row_base <= row_base + SPRITE_W; otherwise hold.
  - Address = row_base_next + (DrawX - px), truncated to ADDR_W.
- Pipeline, total latency 3 clocks from DrawX/DrawY/blank to red/green/blue:
  - Edge 1: rom_addr <= (hit ? address : 0); hit_d1, blank_d1 registered.
  - Edge 2: ROM produces rom_q; hit_d2, blank_d2 registered.
  - Edge 3: output register.
- Output select at edge 3, in priority order:
  - !blank_d2 -> 0.
  - !hit_d2, or rom_q == TRANSP_IDX -> BG_COLOR.
  - mode 2 with blink_phase == 0 -> BG_COLOR.
  - mode 1 -> each channel = min(pal_rgb channel + HL_ADD, 4'hF).
  - otherwise -> pal_rgb.
  - The mode used is the shadow mode delayed alongside the pixel.
- Blink:
  - frame_cnt increments at each frame start.
  - When it reaches BLINK_FRAMES-1, it clears and blink_phase toggles.
  - Runs in all modes, so phase stays coherent across tiles.
- Reset (reset_n low at a rising edge):
  - red, green, blue, rom_addr and all pipeline registers -> 0.
  - row_base, prev_y, frame_cnt -> 0; blink_phase -> 1.
  - Shadow pos -> 0; shadow mode -> 0.
  - After reset mid-frame, output is BG_COLOR or 0 until the next frame start latches the shadows. Pixel data is valid from the first full frame.
- Boundaries:
  - Sprite partly off-screen (px+SPRITE_W > 640): only on-screen pixels draw; no wrap to column 0.
  - pos_y == 0: row_base resets on the frame-start cycle.

Decomposition:
- Package vga_pkg holds:
  - constants H_ACTIVE = 640 and V_ACTIVE = 480;
  - typedef rgb12_t (packed r, g, b nibbles);
  - enum tile_mode_e {MODE_NORMAL, MODE_HIGHLIGHT, MODE_BLINK, MODE_HIDDEN}.
- One natural sub-module, sprite_blink_timer: frame-start detect plus frame_cnt/blink_phase. It outputs frame_start and blink_phase, which are shared by multiple renderer instances.

Test Plan:
- pos=(100,82), mode 0, ROM pattern q = addr[0]: pixel (101,82) -> rom_addr=1 one clock after sample; pal_rgb shown on red/green/blue 3 clocks after sample; (100,83) -> rom_addr=35.
- Pixel (134,82) hits with rom_addr=34; (135,82) and (99,82) -> BG_COLOR; blank low -> output 0 regardless of hit.
- rom_q == TRANSP_IDX inside sprite -> BG_COLOR; mode 1 with pal_rgb=12'hCE2 -> output 12'hFF6 (saturated).
- mode 2, BLINK_FRAMES=2: sprite visible in frames 0–1, BG in frames 2–3, visible in frames 4–5.
- Change pos_x from 100 to 200 at row 240 mid-frame -> the rest of the frame still draws at 100; the next frame draws at 200.
- Pulse reset_n low mid-sprite -> next clock all outputs 0 and blink_phase=1; the correct sprite image reappears in the first full frame.
